// File: rtl/console_pkg.sv
// Shared console constants: special-key ids, escape bytes and the encoder FSM state types.
package console_pkg;

  localparam logic [7:0] KEY_UP    = 8'h01;
  localparam logic [7:0] KEY_DOWN  = 8'h02;
  localparam logic [7:0] KEY_RIGHT = 8'h03;
  localparam logic [7:0] KEY_LEFT  = 8'h04;

  localparam logic [7:0] ESC_BYTE  = 8'h1B;
  localparam logic [7:0] CSI_BYTE  = 8'h5B;
  localparam logic [7:0] CR_BYTE   = 8'h0D;
  localparam logic [7:0] LF_BYTE   = 8'h0A;

  typedef enum logic [1:0] {IDLE, EXP1, EXP2} in_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_HOLD, TX_WAIT} tx_state_e;

  // Arrow ids 0x01..0x04 map onto the final CSI letters 'A'..'D'.
  function automatic logic [7:0] arrow_final(input logic [7:0] id);
    return 8'h40 + id;
  endfunction

endpackage

// File: rtl/key_tx_encoder_if.sv
// Key-event input and UART start/busy handshake between the keyboard side and the encoder.
interface key_tx_encoder_if;
  logic       keyValid;
  logic [7:0] keyCode;
  logic       keySpecial;
  logic       keyReady;
  logic       txStart;
  logic [7:0] txData;
  logic       txBusy;

  modport master (
    output keyValid, keyCode, keySpecial, txBusy,
    input  keyReady, txStart, txData
  );

  modport slave (
    input  keyValid, keyCode, keySpecial, txBusy,
    output keyReady, txStart, txData
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read; pointers carry one extra wrap bit.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign level_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
endmodule

// File: rtl/key_tx_encoder.sv
// Keyboard-event to UART byte encoder: expands arrow keys to ESC [ x and paces bytes to the UART.
// Optional KEY_TX_CRLF_EN: plain CR (0x0D) is sent as the atomic pair CR LF.
module key_tx_encoder
  import console_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  key_tx_encoder_if.slave               bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic [7:0]                    dropCount
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  in_state_e     in_q, in_d;
  tx_state_e     tx_q, tx_d;
  logic [7:0]    fin_q, fin_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    txd_q, txd_d;

  logic          push, pop, drop_evt, is_arrow, is_crlf;
  logic [7:0]    wdata, rdata;
  logic [LW-1:0] level, free_space;
  logic          fifo_full, fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .wdata_i(wdata),
    .pop_i  (pop),
    .rdata_o(rdata),
    .level_o(level),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Space is judged on the pre-pop level so a same-cycle pop never admits a push.
  assign free_space = LW'(FIFO_DEPTH) - level;
  assign is_arrow   = bus.keySpecial && (bus.keyCode inside {KEY_UP, KEY_DOWN, KEY_RIGHT, KEY_LEFT});
`ifdef KEY_TX_CRLF_EN
  assign is_crlf    = !bus.keySpecial && (bus.keyCode == CR_BYTE);
`else
  assign is_crlf    = 1'b0;
`endif

  always_comb begin
    in_d     = in_q;
    fin_d    = fin_q;
    push     = 1'b0;
    wdata    = '0;
    drop_evt = 1'b0;
    case (in_q)
      IDLE: begin
        if (bus.keyValid) begin
          if (is_arrow) begin
            if (free_space >= LW'(3)) begin
              push  = 1'b1;
              wdata = ESC_BYTE;
              fin_d = arrow_final(bus.keyCode);
              in_d  = EXP1;
            end else drop_evt = 1'b1;
          end else if (is_crlf) begin
            if (free_space >= LW'(2)) begin
              push  = 1'b1;
              wdata = CR_BYTE;
              fin_d = LF_BYTE;
              in_d  = EXP2;
            end else drop_evt = 1'b1;
          end else if (!bus.keySpecial) begin
            if (!fifo_full) begin
              push  = 1'b1;
              wdata = bus.keyCode;
            end else drop_evt = 1'b1;
          end
        end
      end
      EXP1: begin
        push     = 1'b1;
        wdata    = CSI_BYTE;
        in_d     = EXP2;
        drop_evt = bus.keyValid;
      end
      EXP2: begin
        push     = 1'b1;
        wdata    = fin_q;
        in_d     = IDLE;
        drop_evt = bus.keyValid;
      end
      default: in_d = IDLE;
    endcase
  end

  assign drop_d = (drop_evt && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

  always_comb begin
    tx_d  = tx_q;
    txd_d = txd_q;
    pop   = 1'b0;
    case (tx_q)
      TX_IDLE: begin
        if (!fifo_empty && !bus.txBusy) begin
          pop   = 1'b1;
          txd_d = rdata;
          tx_d  = TX_START;
        end
      end
      TX_START: tx_d = TX_HOLD;
      TX_HOLD:  tx_d = TX_WAIT;
      TX_WAIT:  if (!bus.txBusy) tx_d = TX_IDLE;
      default:  tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q   <= IDLE;
      tx_q   <= TX_IDLE;
      fin_q  <= '0;
      drop_q <= '0;
      txd_q  <= '0;
    end else begin
      in_q   <= in_d;
      tx_q   <= tx_d;
      fin_q  <= fin_d;
      drop_q <= drop_d;
      txd_q  <= txd_d;
    end
  end

  assign bus.keyReady = (in_q == IDLE) && !rst;
  assign bus.txStart  = (tx_q == TX_START);
  assign bus.txData   = txd_q;
  assign fifoLevel    = level;
  assign dropCount    = drop_q;
endmodule

// File: tb/tb_key_tx_encoder.sv
// Self-checking bench for key_tx_encoder: vector table, corner-case sequences and random traffic.
module tb_key_tx_encoder;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] fifoLevel;
  logic [7:0] dropCount;

  always #5 clk = ~clk;

  key_tx_encoder_if bus();

  key_tx_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .fifoLevel(fifoLevel),
    .dropCount(dropCount)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  // UART model and byte monitor
  logic [7:0] rx[$];
  int         busy_cnt   = 0;
  bit         busy_rand  = 1'b0;
  bit         hold_busy  = 1'b0;
  bit         mon_en     = 1'b0;
  int         cyc        = 0;
  int         last_start = -100;
  logic [7:0] last_tx    = 8'h00;
  logic       rst_q      = 1'b0;

  assign bus.txBusy = (busy_cnt != 0) || hold_busy;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) begin
        last_tx    = 8'h00;
        last_start = -100;
        busy_cnt   = 0;
      end else if (bus.txStart) begin
        rx.push_back(bus.txData);
        check("tx_spacing", int'(cyc - last_start >= 4), 1);
        last_start = cyc;
        last_tx    = bus.txData;
        busy_cnt   = busy_rand ? int'($urandom_range(0, 6)) : 10;
      end else begin
        check("txData_hold", bus.txData, last_tx);
        if (busy_cnt > 0) busy_cnt--;
      end
    end
  end

  // Reference expansion of one key event into its transmitted bytes.
  function automatic int expand(input logic [7:0] code, input bit special,
                                output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2);
    b0 = 8'h00; b1 = 8'h00; b2 = 8'h00;
    if (special) begin
      if (code >= 8'd1 && code <= 8'd4) begin
        b0 = 8'd27; b1 = 8'd91; b2 = 8'd64 + code;
        return 3;
      end
      return 0;
    end
`ifdef KEY_TX_CRLF_EN
    if (code == 8'd13) begin
      b0 = 8'd13; b1 = 8'd10;
      return 2;
    end
`endif
    b0 = code;
    return 1;
  endfunction

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.keyValid = 1'b0;
    repeat (cycles) @(negedge clk);
    check("rst_keyReady", bus.keyReady, 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_key(input logic [7:0] code, input bit special);
    bus.keyValid   = 1'b1;
    bus.keyCode    = code;
    bus.keySpecial = special;
    @(negedge clk);
    bus.keyValid   = 1'b0;
  endtask

  task automatic wait_drain(input int n, input int limit);
    for (int i = 0; i < limit && rx.size() < n; i++) @(negedge clk);
    repeat (20) @(negedge clk);
  endtask

  task automatic compare_rx(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, rx.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx.size(); i++) check(name, rx[i], exp[i]);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         special;
    int         n;
    logic [7:0] b0, b1, b2;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] expq[$];
  int         exp_drop;

  initial begin
    rst = 1'b1;
    bus.keyValid = 1'b0;
    bus.keyCode = 8'h00;
    bus.keySpecial = 1'b0;

    vecs[0] = '{8'h61, 1'b0, 1, 8'h61, 8'h00, 8'h00};
    vecs[1] = '{8'h01, 1'b1, 3, 8'h1B, 8'h5B, 8'h41};
    vecs[2] = '{8'h02, 1'b1, 3, 8'h1B, 8'h5B, 8'h42};
    vecs[3] = '{8'h03, 1'b1, 3, 8'h1B, 8'h5B, 8'h43};
    vecs[4] = '{8'h04, 1'b1, 3, 8'h1B, 8'h5B, 8'h44};
    vecs[5] = '{8'h05, 1'b1, 0, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h00};
    vecs[7] = '{8'hFF, 1'b0, 1, 8'hFF, 8'h00, 8'h00};
`ifdef KEY_TX_CRLF_EN
    vecs[8] = '{8'h0D, 1'b0, 2, 8'h0D, 8'h0A, 8'h00};
`else
    vecs[8] = '{8'h0D, 1'b0, 1, 8'h0D, 8'h00, 8'h00};
`endif

    // Reset state
    do_reset(3);
    mon_en = 1'b1;
    exp_drop = 0;
    check("reset_keyReady", bus.keyReady, 1);
    check("reset_level", fifoLevel, 0);
    check("reset_drop", dropCount, 0);
    check("reset_txStart", bus.txStart, 0);
    check("reset_txData", bus.txData, 0);

    // Vector table
    foreach (vecs[i]) begin
      rx.delete();
      expq.delete();
      if (vecs[i].n > 0) expq.push_back(vecs[i].b0);
      if (vecs[i].n > 1) expq.push_back(vecs[i].b1);
      if (vecs[i].n > 2) expq.push_back(vecs[i].b2);
      pulse_key(vecs[i].code, vecs[i].special);
      wait_drain(vecs[i].n, 200);
      compare_rx("vec_bytes", expq);
      check("vec_level", fifoLevel, 0);
      check("vec_drop", dropCount, exp_drop);
    end

    // keyReady drops for the two expansion cycles after an arrow is accepted
    rx.delete();
    pulse_key(8'h01, 1'b1);
    check("exp1_keyReady", bus.keyReady, 0);
    @(negedge clk);
    check("exp2_keyReady", bus.keyReady, 0);
    @(negedge clk);
    check("back_keyReady", bus.keyReady, 1);
    wait_drain(3, 200);
    expq = '{8'h1B, 8'h5B, 8'h41};
    compare_rx("up_bytes", expq);

    // Key arriving during expansion is dropped, sequence survives
    rx.delete();
    bus.keyValid = 1'b1; bus.keyCode = 8'h02; bus.keySpecial = 1'b1;
    @(negedge clk);
    bus.keyCode = 8'h55; bus.keySpecial = 1'b0;
    @(negedge clk);
    bus.keyValid = 1'b0;
    exp_drop++;
    check("busy_drop", dropCount, exp_drop);
    wait_drain(3, 200);
    expq = '{8'h1B, 8'h5B, 8'h42};
    compare_rx("busy_seq", expq);

    // Fill to capacity, then a push coinciding with the first pop is rejected
    do_reset(1);
    exp_drop = 0;
    hold_busy = 1'b1;
    rx.delete();
    expq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      pulse_key(8'h30 + 8'(i), 1'b0);
      expq.push_back(8'h30 + 8'(i));
    end
    check("full_level", fifoLevel, DEPTH);
    check("full_drop0", dropCount, 0);
    hold_busy = 1'b0;
    pulse_key(8'h7A, 1'b0);
    check("full_drop1", dropCount, 1);
    check("full_pop_level", fifoLevel, DEPTH - 1);
    wait_drain(DEPTH, 1000);
    compare_rx("full_order", expq);

    // Level 14: a 3-byte arrow no longer fits and is dropped whole
    do_reset(1);
    hold_busy = 1'b1;
    rx.delete();
    expq.delete();
    for (int i = 0; i < DEPTH - 2; i++) begin
      pulse_key(8'h40 + 8'(i), 1'b0);
      expq.push_back(8'h40 + 8'(i));
    end
    pulse_key(8'h03, 1'b1);
    check("l14_level", fifoLevel, DEPTH - 2);
    check("l14_drop", dropCount, 1);
    pulse_key(8'h21, 1'b0);
    expq.push_back(8'h21);
    check("l14_plain_level", fifoLevel, DEPTH - 1);
    hold_busy = 1'b0;
    wait_drain(DEPTH - 1, 1000);
    compare_rx("l14_order", expq);

    // Reset while waiting on the UART with bytes queued
    do_reset(1);
    rx.delete();
    for (int i = 0; i < 6; i++) pulse_key(8'h61 + 8'(i), 1'b0);
    check("midtx_level", fifoLevel, 5);
    check("midtx_sent", rx.size(), 1);
    do_reset(1);
    check("midtx_rst_level", fifoLevel, 0);
    check("midtx_rst_drop", dropCount, 0);
    repeat (60) @(negedge clk);
    check("midtx_no_tx", rx.size(), 1);

    // Random bursts against the reference expansion
    do_reset(1);
    exp_drop = 0;
    busy_rand = 1'b1;
    for (int r = 0; r < 30; r++) begin
      int nev;
      rx.delete();
      expq.delete();
      nev = $urandom_range(1, 5);
      for (int e = 0; e < nev; e++) begin
        logic [7:0] code, b0, b1, b2;
        bit         sp;
        int         sel, n;
        sel = $urandom_range(0, 9);
        if (sel < 4) begin
          code = 8'($urandom_range(0, 255)); sp = 1'b0;
        end else if (sel < 8) begin
          code = 8'($urandom_range(0, 6)); sp = 1'b1;
        end else begin
          code = 8'h0D; sp = 1'b0;
        end
        n = expand(code, sp, b0, b1, b2);
        if (n > 0) expq.push_back(b0);
        if (n > 1) expq.push_back(b1);
        if (n > 2) expq.push_back(b2);
        for (int j = 0; j < 10 && !bus.keyReady; j++) @(negedge clk);
        if (!bus.keyReady) check("rand_ready_timeout", bus.keyReady, 1);
        pulse_key(code, sp);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain(expq.size(), 600);
      compare_rx("rand_bytes", expq);
      check("rand_drop", dropCount, exp_drop);
      check("rand_level", fifoLevel, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/key_tx_encoder.md
KEY_TX_ENCODER -- requirements
Module: key_tx_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, byte capacity of the transmit queue; power of two, minimum 4.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 keyValid  input  1  single-cycle pulse: keyboard decoder has a key event.
REQ-005 keyCode  input  8  ASCII byte, or special-key id when keySpecial=1.
REQ-006 keySpecial  input  1  qualifies keyCode as special-key id.
REQ-007 keyReady  output  1  high when a key event is accepted this cycle.
REQ-008 txStart  output  1  single-cycle start pulse to the UART transmitter.
REQ-009 txData  output  8  byte to transmit; valid in the txStart cycle.
REQ-010 txBusy  input  1  UART transmitter busy; rises the cycle after an accepted start.
REQ-011 fifoLevel  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.
REQ-012 dropCount  output  8  key events discarded since reset, saturating at 255.

Function
REQ-013 Plain key (keySpecial=0): enqueue keyCode, 1 byte.
REQ-014 Special ids 0x01/0x02/0x03/0x04 (up/down/right/left): enqueue 0x1B, 0x5B, then 0x41/0x42/0x43/0x44 respectively.
REQ-015 Any other special id: discard, no enqueue, no dropCount change.
REQ-016 Input FSM states IDLE, EXP1, EXP2; a 3-byte sequence writes one byte per cycle, IDLE->EXP1->EXP2->IDLE.
REQ-017 keyReady = (state==IDLE); keyValid while keyReady=0 drops the event and increments dropCount.
REQ-018 Event accepted only if free space >= its byte count (1 or 3); otherwise the whole event is dropped and dropCount increments; sequences are never partially queued.
REQ-019 Output FSM states TX_IDLE, TX_START, TX_HOLD, TX_WAIT.
REQ-020 TX_IDLE: FIFO non-empty and txBusy=0 -> pop head, go TX_START.
REQ-021 TX_START: txStart=1 for exactly one cycle with popped byte on txData -> TX_HOLD.
REQ-022 TX_HOLD: one cycle ignoring txBusy -> TX_WAIT.
REQ-023 TX_WAIT: stay while txBusy=1; txBusy=0 -> TX_IDLE.
REQ-024 Minimum spacing between txStart pulses is 4 cycles; bytes leave in FIFO order.
REQ-025 Simultaneous push and pop in one cycle is legal; fifoLevel unchanged; a full FIFO with concurrent pop still rejects a push (space check uses pre-pop level).
REQ-026 Read/write pointers wrap modulo FIFO_DEPTH; full/empty from an extra pointer bit.
REQ-027 txData holds last transmitted byte when txStart=0.

Reset
REQ-028 rst=1 on a rising edge: both FSMs to idle, FIFO emptied, fifoLevel=0, dropCount=0, txStart=0, txData=0x00, keyReady=0 in the reset cycle, 1 afterwards.
REQ-029 Reset mid-sequence or mid-transmission abandons the event/byte; no txStart for pre-reset data after rst deasserts.

Configuration
REQ-030 Macro KEY_TX_CRLF_EN: when defined, plain key 0x0D enqueues 0x0D,0x0A as a 2-byte atomic sequence via the expansion FSM (space check 2 bytes); when undefined, 0x0D enqueues 0x0D only.

Structure
REQ-031 Shared package console_pkg holds special-key id constants, ESC (0x1B) and CSI byte (0x5B) constants, and the FSM state enums.
REQ-032 Queue storage is sub-module sync_fifo (parameterised width 8, depth FIFO_DEPTH, push/pop/level/full/empty); FSMs and expansion stay in key_tx_encoder.

Verification
REQ-033 Plain 'a' (0x61) pulse, txBusy model 10 cycles -> one txStart, txData=0x61, fifoLevel back to 0.
REQ-034 Special 0x01 -> txStart bytes 0x1B,0x5B,0x41 in order, keyReady low 2 cycles after acceptance.
REQ-035 txBusy held high, 16 plain keys then 1 more -> fifoLevel=16, 17th dropped, dropCount=1; with level 14 a special key is dropped whole.
REQ-036 Key pulse during EXP1 -> dropped, dropCount increments, sequence intact.
REQ-037 rst asserted during TX_WAIT with 5 bytes queued -> fifoLevel=0, dropCount=0, no further txStart.
REQ-038 KEY_TX_CRLF_EN defined: 0x0D -> 0x0D,0x0A transmitted; undefined: 0x0D only.
